serializer_stream_arbiter: RTL
==============================

# serializer_stream_arbiter

- Merges the two encoded byte streams of the protobuf serializer into the single output byte FIFO, in ascending field-index order:
  - the varint stream, from the varint output FIFO/index pair;
  - the raw-data stream, from the raw-data output FIFO/index pair.
- Grants one stream per field and holds the grant until that field's last byte, so fields are never interleaved.
- Tracks per-message byte/field counts and flags ordering violations.
- Sits between the encoder back-ends and the AXI read-side output FIFO.

## Interface
Parameters:
- CNT_W, 16, width of byte and field counters.
- TIMEOUT_CYCLES, 256, stall limit mid-field (only with SER_ARB_TIMEOUT_EN).

Ports:
- clk  in  1  clock.
- reset_n  in  1  synchronous, active-low reset.
- vi_empty  in  1  varint stream FIFO empty (show-ahead).
- vi_q  in  8  varint head byte.
- vi_index_q  in  10  varint head field index.
- vi_last  in  1  head byte is last byte of its field.
- vi_done  in  1  varint producer has no further fields this message (level).
- vi_pop  out  1  pop varint stream.
- rd_empty, rd_q, rd_index_q, rd_last, rd_done, rd_pop  same widths/meanings for the raw-data stream.
- out_full  in  1  output FIFO full.
- out_data  out  8  byte to output FIFO.
- out_push  out  1  write output FIFO.
- msg_done  out  1  one-cycle pulse at end of message.
- byte_count  out  CNT_W  bytes pushed in current message.
- field_count  out  CNT_W  fields completed in current message.
- order_err  out  1  sticky: a granted field index ≤ previous field index.
- stall_err  out  1  sticky: mid-field timeout (0 when macro absent).

## Operation
- State machine: IDLE, LOCK_V, LOCK_R, DONE.
- IDLE, grant varint (→LOCK_V) when !vi_empty and either:
  - rd_empty && rd_done, or
  - !rd_empty && vi_index_q < rd_index_q.
- IDLE, grant raw (→LOCK_R) under the symmetric rule.
- Equal indices with both heads valid: varint wins. This also sets order_err.
- Only one stream non-empty and the other not done: stay IDLE and wait.
- IDLE → DONE when both streams are empty and both done.
- LOCK_x:
  - out_push = !x_empty && !out_full.
  - x_pop = out_push.
  - out_data = x_q.
  - out_push with x_last → return to IDLE, field_count+1.
- Every out_push increments byte_count.
- On grant, latch the head index as prev_index. order_err sets if this is not the first field and the new index ≤ prev_index.
- DONE:
  - msg_done=1 for one cycle.
  - Clear byte_count, field_count and the first-field flag.
  - → IDLE.
- Errors are cleared only by reset.
- Counters saturate at all-ones; they do not wrap.
- out_data is 0 whenever out_push is 0.

## Timing
- Reset values:
  - state IDLE.
  - All outputs 0: out_push, vi_pop, rd_pop, out_data, msg_done, byte_count, field_count, order_err, stall_err.
- out_push and x_pop are combinational from state, x_empty and out_full. out_data, the pops and out_push are in the same cycle.
- Grant is registered:
  - first byte of a field is pushed no earlier than 1 cycle after the IDLE decision;
  - field overhead is 1 cycle;
  - sustained throughput is 1 byte/cycle inside a field.
- out_full stalls LOCK_x without state change. No push and no pop occur while out_full=1.
- x_empty mid-field: hold LOCK_x and wait for the next byte; the grant is never lost.
- Simultaneous last-byte push and other stream becoming non-empty: the return to IDLE occurs, and arbitration happens on the next cycle.
- vi_done/rd_done are sampled only in IDLE.
- reset_n low mid-field: next edge returns to IDLE, counters clear, partial field is abandoned, no further pops.
- Both empty and done while in IDLE with zero fields emitted: DONE is still entered, and msg_done pulses with counts 0.

## Configuration
- Macro SER_ARB_TIMEOUT_EN.
- Defined:
  - a stall counter increments each LOCK_x cycle with x_empty=1, and clears on any push;
  - reaching TIMEOUT_CYCLES sets stall_err and forces IDLE, abandoning the field; field_count is not incremented.
- Undefined: no stall counter; LOCK_x waits indefinitely; stall_err tied 0; TIMEOUT_CYCLES unused.

## Test plan
- Varint field idx 1 (bytes 0x08,0x96 last), raw field idx 2 (0x41,0x42,0x43 last), both done → out sequence 08 96 41 42 43; field_count=2, byte_count=5; msg_done one pulse; order_err=0.
- Raw field idx 3 queued, varint empty and not done for 20 cycles, then varint idx 2 arrives → varint bytes emitted first; no push during the wait.
- out_full held high 5 cycles mid raw field → no pops, no pushes; resumes with the next byte in order; no loss or duplication.
- Both heads idx 5 → varint granted first; order_err=1, held until reset.
- Reset_n low after 2 of 4 bytes of a field → all outputs 0 next cycle; after release, a new message counts from 0.
- With SER_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=8, locked stream starved 8 cycles → stall_err=1, state IDLE, field_count unchanged. Without the macro, same stimulus → still locked, stall_err=0.

Source files
------------

// File: rtl/serializer_stream_arbiter.sv
// Merges the varint and raw-data byte streams into one output FIFO, one whole field at a time.
// Optional mid-field stall timeout is enabled by defining SER_ARB_TIMEOUT_EN.
module serializer_stream_arbiter #(
   parameter int CNT_W          = 16,
   parameter int TIMEOUT_CYCLES = 256
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             vi_empty,
   input  logic [7:0]       vi_q,
   input  logic [9:0]       vi_index_q,
   input  logic             vi_last,
   input  logic             vi_done,
   output logic             vi_pop,
   input  logic             rd_empty,
   input  logic [7:0]       rd_q,
   input  logic [9:0]       rd_index_q,
   input  logic             rd_last,
   input  logic             rd_done,
   output logic             rd_pop,
   input  logic             out_full,
   output logic [7:0]       out_data,
   output logic             out_push,
   output logic             msg_done,
   output logic [CNT_W-1:0] byte_count,
   output logic [CNT_W-1:0] field_count,
   output logic             order_err,
   output logic             stall_err
);

   typedef enum logic [1:0] {
      IDLE,
      LOCK_V,
      LOCK_R,
      DONE
   } state_t;

   if (TIMEOUT_CYCLES < 2) begin : g_timeout_chk
      $error("TIMEOUT_CYCLES must be at least 2");
   end

   state_t           state_q, state_d;
   logic [CNT_W-1:0] byte_count_q, byte_count_d;
   logic [CNT_W-1:0] field_count_q, field_count_d;
   logic [9:0]       prev_index_q, prev_index_d;
   logic             seen_q, seen_d;
   logic             order_err_q, order_err_d;
   logic             msg_done_q, msg_done_d;

   logic             lock_v, lock_r, locked;
   logic             sel_empty, sel_last;
   logic [7:0]       sel_q;
   logic             push;
   logic             grant_v, grant_r, all_done;

   always_comb begin
      lock_v    = (state_q == LOCK_V);
      lock_r    = (state_q == LOCK_R);
      locked    = lock_v || lock_r;
      sel_empty = lock_v ? vi_empty : rd_empty;
      sel_q     = lock_v ? vi_q : rd_q;
      sel_last  = lock_v ? vi_last : rd_last;
      // Gated by reset_n so an abandoned field loses no byte on the reset edge.
      push      = locked && !sel_empty && !out_full && reset_n;
   end

   assign out_push = push;
   assign vi_pop   = push && lock_v;
   assign rd_pop   = push && lock_r;
   assign out_data = push ? sel_q : 8'h00;

   always_comb begin
      grant_v  = !vi_empty &&
                 ((rd_empty && rd_done) ||
                  (!rd_empty && (vi_index_q <= rd_index_q)));
      grant_r  = !rd_empty &&
                 ((vi_empty && vi_done) ||
                  (!vi_empty && (rd_index_q < vi_index_q)));
      all_done = vi_empty && rd_empty && vi_done && rd_done;
   end

`ifdef SER_ARB_TIMEOUT_EN
   localparam int STALL_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [STALL_W-1:0] stall_q, stall_d;
   logic               stall_err_q, stall_err_d;
   logic               timeout;

   always_comb begin
      stall_d     = stall_q;
      stall_err_d = stall_err_q;
      timeout     = 1'b0;
      if (!locked || push) begin
         stall_d = '0;
      end else if (sel_empty) begin
         if (stall_q == STALL_W'(TIMEOUT_CYCLES - 1)) begin
            timeout     = 1'b1;
            stall_err_d = 1'b1;
            stall_d     = '0;
         end else begin
            stall_d = stall_q + STALL_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         stall_q     <= '0;
         stall_err_q <= 1'b0;
      end else begin
         stall_q     <= stall_d;
         stall_err_q <= stall_err_d;
      end
   end

   assign stall_err = stall_err_q;
`else
   logic timeout;

   assign timeout   = 1'b0;
   assign stall_err = 1'b0;
`endif

   always_comb begin
      state_d       = state_q;
      byte_count_d  = byte_count_q;
      field_count_d = field_count_q;
      prev_index_d  = prev_index_q;
      seen_d        = seen_q;
      order_err_d   = order_err_q;
      msg_done_d    = 1'b0;

      if (push && !(&byte_count_q)) begin
         byte_count_d = byte_count_q + CNT_W'(1);
      end

      unique case (state_q)
         IDLE: begin
            if (grant_v) begin
               state_d      = LOCK_V;
               prev_index_d = vi_index_q;
               seen_d       = 1'b1;
               if ((seen_q && (vi_index_q <= prev_index_q)) ||
                   (!rd_empty && (vi_index_q == rd_index_q))) begin
                  order_err_d = 1'b1;
               end
            end else if (grant_r) begin
               state_d      = LOCK_R;
               prev_index_d = rd_index_q;
               seen_d       = 1'b1;
               if (seen_q && (rd_index_q <= prev_index_q)) begin
                  order_err_d = 1'b1;
               end
            end else if (all_done) begin
               state_d    = DONE;
               msg_done_d = 1'b1;
            end
         end
         LOCK_V, LOCK_R: begin
            if (push && sel_last) begin
               state_d = IDLE;
               if (!(&field_count_q)) begin
                  field_count_d = field_count_q + CNT_W'(1);
               end
            end else if (timeout) begin
               state_d = IDLE;
            end
         end
         DONE: begin
            state_d       = IDLE;
            byte_count_d  = '0;
            field_count_d = '0;
            seen_d        = 1'b0;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q       <= IDLE;
         byte_count_q  <= '0;
         field_count_q <= '0;
         prev_index_q  <= '0;
         seen_q        <= 1'b0;
         order_err_q   <= 1'b0;
         msg_done_q    <= 1'b0;
      end else begin
         state_q       <= state_d;
         byte_count_q  <= byte_count_d;
         field_count_q <= field_count_d;
         prev_index_q  <= prev_index_d;
         seen_q        <= seen_d;
         order_err_q   <= order_err_d;
         msg_done_q    <= msg_done_d;
      end
   end

   assign byte_count  = byte_count_q;
   assign field_count = field_count_q;
   assign order_err   = order_err_q;
   assign msg_done    = msg_done_q;

endmodule
